// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the fetch (I) and load (D) requesters and rom_arbiter.
// Handshake: a requester raises req with a stable byte address and holds both until it
// sees a one-cycle ack. rdata and err are valid in the ack cycle, and rdata then holds
// until that port's next ack.
interface rom_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_req;
  logic [31:0]      i_addr;
  logic             i_ack;
  logic [WIDTH-1:0] i_rdata;
  logic             i_err;
  logic             d_req;
  logic [31:0]      d_addr;
  logic             d_ack;
  logic [WIDTH-1:0] d_rdata;
  logic             d_err;

  modport master (
    output i_req, i_addr, d_req, d_addr,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port (fetch/load) arbiter and sequencer for an asynchronous-read instruction ROM.
// Define ROM_ARB_RR_EN for round-robin conflict resolution; otherwise fetch has fixed priority.
module rom_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic                  busy,
  output logic [1:0]            dbg_state,
  output logic                  dbg_last_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  state_t      state;
  logic        gnt_d;
  logic        err_pending;
  logic        last_grant;
  logic        pick_d;
  logic [31:0] sel_addr;
  logic        sel_err;

  always_comb begin
`ifdef ROM_ARB_RR_EN
    pick_d = bus.d_req && (!bus.i_req || (last_grant == GNT_I));
`else
    pick_d = bus.d_req && !bus.i_req;
`endif
    sel_addr = pick_d ? bus.d_addr : bus.i_addr;
    // Misaligned or beyond the ROM: still costs a full transaction, data is discarded.
    sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_WIDTH+2] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_d       <= GNT_I;
      err_pending <= 1'b0;
      last_grant  <= GNT_D;
      rom_addr    <= '0;
      bus.i_ack   <= 1'b0;
      bus.i_rdata <= '0;
      bus.i_err   <= 1'b0;
      bus.d_ack   <= 1'b0;
      bus.d_rdata <= '0;
      bus.d_err   <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            gnt_d       <= pick_d;
            last_grant  <= pick_d;
            rom_addr    <= sel_addr[ADDR_WIDTH+1:2];
            err_pending <= sel_err;
            state       <= ADDR;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          if (gnt_d) begin
            bus.d_rdata <= err_pending ? '0 : rom_data;
            bus.d_err   <= err_pending;
            bus.d_ack   <= 1'b1;
          end else begin
            bus.i_rdata <= err_pending ? '0 : rom_data;
            bus.i_err   <= err_pending;
            bus.i_ack   <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: ROM word k holds 0xA000_0000 + k; DUT is sampled on falling edges.
module tb_rom_arbiter;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 10;

  logic                  clk;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0]      rom_data;
  logic                  busy;
  logic [1:0]            dbg_state;
  logic                  dbg_last_grant;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [WIDTH:0] exp_q[$];

  rom_arbiter_if #(.WIDTH(WIDTH)) bus ();

  rom_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .busy           (busy),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  // clock / reset / ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = 32'hA000_0000 + {{(WIDTH-ADDR_WIDTH){1'b0}}, rom_addr};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // driver tasks
  task automatic wait_ack(input bit port_d, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    @(posedge clk);
    while (!seen && lat <= 8) begin
      @(negedge clk);
      if (port_d ? bus.d_ack : bus.i_ack) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0;
    repeat (2) @(negedge clk);
    chk_cnt++; if ({busy, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000", {busy, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err});
    else pass_cnt++;
    chk_cnt++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0)
      $display("FAIL reset_rdata: got %h/%h required 0/0", bus.i_rdata, bus.d_rdata); else pass_cnt++;
    chk_cnt++; if (rom_addr !== 10'd0) $display("FAIL reset_rom_addr: got %0d required 0", rom_addr); else pass_cnt++;
    chk_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d required 0", dbg_state); else pass_cnt++;
    chk_cnt++; if (dbg_last_grant !== 1'b1) $display("FAIL reset_last_grant: got %b required 1", dbg_last_grant); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({busy, bus.i_ack, dbg_state} !== 4'b1001)
      $display("FAIL fetch_addr_phase: got busy=%b ack=%b state=%0d required 1 0 1", busy, bus.i_ack, dbg_state);
    else pass_cnt++;
    chk_cnt++; if (rom_addr !== 10'd4) $display("FAIL fetch_rom_addr: got %0d required 4", rom_addr); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({busy, bus.i_ack, dbg_state} !== 4'b1010)
      $display("FAIL fetch_data_phase: got busy=%b ack=%b state=%0d required 1 0 2", busy, bus.i_ack, dbg_state);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({bus.i_ack, bus.i_err, busy, bus.d_ack} !== 4'b1000)
      $display("FAIL fetch_ack: got ack=%b err=%b busy=%b d_ack=%b required 1 0 0 0", bus.i_ack, bus.i_err, busy, bus.d_ack);
    else pass_cnt++;
    chk_cnt++; if (bus.i_rdata !== 32'hA000_0004) $display("FAIL fetch_rdata: got %h required a0000004", bus.i_rdata); else pass_cnt++;
    bus.i_req = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({bus.i_ack, busy} !== 2'b00)
      $display("FAIL fetch_ack_pulse: got ack=%b busy=%b required 0 0", bus.i_ack, busy);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    int lat;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0000_0006;
    addrs[1] = 32'h0000_1000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_addr = addrs[k];
      wait_ack(1'b1, lat);
      chk_cnt++; if (lat !== 2) $display("FAIL err%0d_latency: got %0d required 2", k, lat); else pass_cnt++;
      chk_cnt++; if ({bus.d_err, bus.d_rdata} !== {1'b1, 32'h0})
        $display("FAIL err%0d_result: got err=%b rdata=%h required 1 0", k, bus.d_err, bus.d_rdata);
      else pass_cnt++;
      chk_cnt++; if ({bus.i_ack, bus.i_err, bus.i_rdata} !== {2'b00, 32'hA000_0004})
        $display("FAIL err%0d_i_untouched: got ack=%b err=%b rdata=%h required 0 0 a0000004", k, bus.i_ack, bus.i_err, bus.i_rdata);
      else pass_cnt++;
      bus.d_req = 1'b0;
    end
  endtask

  task automatic test_boundary();
    int lat;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0FFC;
    wait_ack(1'b0, lat);
    chk_cnt++; if (lat !== 2) $display("FAIL boundary_latency: got %0d required 2", lat); else pass_cnt++;
    chk_cnt++; if ({bus.i_err, bus.i_rdata} !== {1'b0, 32'hA000_03FF})
      $display("FAIL boundary_result: got err=%b rdata=%h required 0 a00003ff", bus.i_err, bus.i_rdata);
    else pass_cnt++;
    bus.i_req = 1'b0;
  endtask

  task automatic test_conflict();
    logic [WIDTH:0] got;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back({1'b0, 32'hA000_0002});
`ifdef ROM_ARB_RR_EN
    exp_q.push_back({1'b1, 32'hA000_0003});
`else
    exp_q.push_back({1'b0, 32'hA000_0002});
`endif
    exp_q.push_back({1'b0, 32'hA000_0002});
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0008;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_000C;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(posedge clk); @(negedge clk);
      chk_cnt++; if (bus.i_ack && bus.d_ack) $display("FAIL conflict_exclusive: both acks high in cycle %0d, required one at most", cyc);
      else pass_cnt++;
      if (bus.i_ack || bus.d_ack) begin
        got = bus.d_ack ? {1'b1, bus.d_rdata} : {1'b0, bus.i_rdata};
        chk_cnt++; if (cyc % 3 != 2) $display("FAIL conflict_ack_cycle: got ack in cycle %0d required cycle 2/5/8", cyc);
        else pass_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL conflict_extra_ack: got port=%b data=%h required no ack", got[WIDTH], got[WIDTH-1:0]);
        else if (got !== exp_q[0]) begin
          $display("FAIL conflict_grant: got port=%b data=%h required port=%b data=%h", got[WIDTH], got[WIDTH-1:0], exp_q[0][WIDTH], exp_q[0][WIDTH-1:0]);
          void'(exp_q.pop_front());
        end else begin
          pass_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL conflict_missing_acks: got %0d outstanding required 0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_late_request();
    int lat;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0020;
    @(posedge clk); @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_0024;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({bus.i_ack, bus.d_ack} !== 2'b00) $display("FAIL late_early_ack: got %b required 00", {bus.i_ack, bus.d_ack});
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if ({bus.i_ack, bus.d_ack, bus.i_rdata} !== {2'b10, 32'hA000_0008})
      $display("FAIL late_i_ack: got i=%b d=%b rdata=%h required 1 0 a0000008", bus.i_ack, bus.d_ack, bus.i_rdata);
    else pass_cnt++;
    bus.i_req = 1'b0;
    wait_ack(1'b1, lat);
    chk_cnt++; if (lat !== 2) $display("FAIL late_d_latency: got %0d after i_ack+1 required 2", lat); else pass_cnt++;
    chk_cnt++; if ({bus.d_err, bus.d_rdata} !== {1'b0, 32'hA000_0009})
      $display("FAIL late_d_result: got err=%b rdata=%h required 0 a0000009", bus.d_err, bus.d_rdata);
    else pass_cnt++;
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0014;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({busy, dbg_state, bus.i_ack, bus.d_ack} !== 5'b0)
      $display("FAIL midrst_state: got busy=%b state=%0d acks=%b%b required 0 0 00", busy, dbg_state, bus.i_ack, bus.d_ack);
    else pass_cnt++;
    chk_cnt++; if ({rom_addr, bus.i_rdata, bus.d_rdata} !== '0)
      $display("FAIL midrst_regs: got rom_addr=%0d i=%h d=%h required 0 0 0", rom_addr, bus.i_rdata, bus.d_rdata);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    chk_cnt++; if (bus.i_ack !== 1'b0) $display("FAIL midrst_no_ack: got %b required 0", bus.i_ack); else pass_cnt++;
    rst_n = 1'b1;
    wait_ack(1'b0, lat);
    chk_cnt++; if (lat !== 2) $display("FAIL midrst_reissue_latency: got %0d required 2", lat); else pass_cnt++;
    chk_cnt++; if (bus.i_rdata !== 32'hA000_0005) $display("FAIL midrst_reissue_rdata: got %h required a0000005", bus.i_rdata);
    else pass_cnt++;
    bus.i_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_errors();
    test_boundary();
    test_conflict();
    test_late_request();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
